// File: rtl/ucsbece154_icache_pkg.sv
`default_nettype none
// ============================================================================
// ucsbece154_icache_pkg : shared state encoding and address-field helpers
// Revision: 1.0
// ============================================================================
package ucsbece154_icache_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT          = 3'd1,
        FILL_DEMAND   = 3'd2,
        FILL_PREFETCH = 3'd3,
        PROMOTE       = 3'd4
    } state_t;

    localparam int BYTE_BITS = 2;

    function automatic int word_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int set_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets, input int block_words);
        return 32 - BYTE_BITS - $clog2(num_sets) - $clog2(block_words);
    endfunction

    // Each burst returns the demand block followed by the next sequential block.
    function automatic int burst_len(input int block_words);
        return 2 * block_words;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// ucsbece154_icache_fill_ctrl : miss/fill state machine and burst beat counter
// Revision: 1.0
// ============================================================================
module ucsbece154_icache_fill_ctrl
    import ucsbece154_icache_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_BITS    = $clog2(2 * BLOCK_WORDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_enable,
    input  logic                cache_hit,
    input  logic                buf_hit,
    input  logic                mem_data_ready,
    output state_t              state,
    output logic [CNT_BITS-1:0] fill_count,
    output logic                ready,
    output logic                miss,
    output logic                demand_we,
    output logic                demand_last,
    output logic                prefetch_we,
    output logic                prefetch_last,
    output logic                promote,
    output logic                mem_read_request
);

    state_t              state_next;
    logic [CNT_BITS-1:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            fill_count       <= '0;
            mem_read_request <= 1'b0;
        end else begin
            state            <= state_next;
            fill_count       <= count_next;
            mem_read_request <= miss;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = fill_count;
        miss          = 1'b0;
        demand_we     = 1'b0;
        demand_last   = 1'b0;
        prefetch_we   = 1'b0;
        prefetch_last = 1'b0;
        promote       = 1'b0;
        ready         = 1'b0;
        case (state)
            IDLE: begin
                if (read_enable) begin
                    if (cache_hit) begin
                        ready = 1'b1;
                    end else if (buf_hit) begin
                        ready      = 1'b1;
                        state_next = PROMOTE;
                    end else begin
                        miss       = 1'b1;
                        count_next = '0;
                        state_next = WAIT;
                    end
                end
            end
            WAIT, FILL_DEMAND: begin
                if (mem_data_ready) begin
                    // First beat is the critical word, forwarded straight to fetch.
                    ready      = (state == WAIT);
                    demand_we  = 1'b1;
                    count_next = fill_count + CNT_BITS'(1);
                    if (fill_count == CNT_BITS'(BLOCK_WORDS - 1)) begin
                        demand_last = 1'b1;
                        state_next  = FILL_PREFETCH;
                    end else begin
                        state_next  = FILL_DEMAND;
                    end
                end
            end
            FILL_PREFETCH: begin
                if (mem_data_ready) begin
                    prefetch_we = 1'b1;
                    count_next  = fill_count + CNT_BITS'(1);
                    if (fill_count == CNT_BITS'(2 * BLOCK_WORDS - 1)) begin
                        prefetch_last = 1'b1;
                        count_next    = '0;
                        state_next    = IDLE;
                    end
                end
            end
            PROMOTE: begin
                promote    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ucsbece154_icache.sv
`default_nettype none
// ============================================================================
// ucsbece154_icache : direct-mapped instruction cache with next-block prefetch
// Revision: 1.0
// ============================================================================
module ucsbece154_icache
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int WORD_BITS = word_bits(BLOCK_WORDS);
    localparam int SET_BITS  = set_bits(NUM_SETS);
    localparam int TAG_BITS  = tag_bits(NUM_SETS, BLOCK_WORDS);
    localparam int BLK_BITS  = 32 - BYTE_BITS - WORD_BITS;
    localparam int CNT_BITS  = $clog2(burst_len(BLOCK_WORDS));

    logic [NUM_SETS-1:0] valid;
    logic [TAG_BITS-1:0] tags [NUM_SETS];
    logic [31:0]         data [NUM_SETS][BLOCK_WORDS];
    logic                buf_valid;
    logic [BLK_BITS-1:0] buf_blk;
    logic [31:0]         buf_data [BLOCK_WORDS];

    state_t              state;
    logic [CNT_BITS-1:0] fill_count;
    logic cache_hit, buf_hit, miss, demand_we, demand_last;
    logic prefetch_we, prefetch_last, promote;

    logic [WORD_BITS-1:0] word_idx, miss_word, demand_slot, prefetch_slot;
    logic [SET_BITS-1:0]  set_idx, miss_set, buf_set;
    logic [TAG_BITS-1:0]  tag, miss_tag, buf_tag;
    logic [BLK_BITS-1:0]  blk, miss_blk;

    assign word_idx = ReadAddress[BYTE_BITS +: WORD_BITS];
    assign set_idx  = ReadAddress[BYTE_BITS + WORD_BITS +: SET_BITS];
    assign tag      = ReadAddress[31 -: TAG_BITS];
    assign blk      = ReadAddress[31 -: BLK_BITS];

    // Fill addressing comes from the latched miss address, never the live fetch.
    assign miss_word     = MemReadAddress[BYTE_BITS +: WORD_BITS];
    assign miss_set      = MemReadAddress[BYTE_BITS + WORD_BITS +: SET_BITS];
    assign miss_tag      = MemReadAddress[31 -: TAG_BITS];
    assign miss_blk      = MemReadAddress[31 -: BLK_BITS];
    assign demand_slot   = miss_word + fill_count[WORD_BITS-1:0];
    assign prefetch_slot = fill_count[WORD_BITS-1:0];

    assign buf_set = buf_blk[SET_BITS-1:0];
    assign buf_tag = buf_blk[BLK_BITS-1:SET_BITS];

    assign cache_hit = valid[set_idx] && (tags[set_idx] == tag);
    assign buf_hit   = buf_valid && (buf_blk == blk);

    logic unused_bits;
    assign unused_bits = &{1'b0, ReadAddress[1:0], fill_count[CNT_BITS-1]};

    ucsbece154_icache_fill_ctrl #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .CNT_BITS    (CNT_BITS)
    ) u_fill_ctrl (
        .clk              (clk),
        .reset            (reset),
        .read_enable      (ReadEnable),
        .cache_hit        (cache_hit),
        .buf_hit          (buf_hit),
        .mem_data_ready   (MemDataReady),
        .state            (state),
        .fill_count       (fill_count),
        .ready            (Ready),
        .miss             (miss),
        .demand_we        (demand_we),
        .demand_last      (demand_last),
        .prefetch_we      (prefetch_we),
        .prefetch_last    (prefetch_last),
        .promote          (promote),
        .mem_read_request (MemReadRequest)
    );

    always_comb begin
        Instruction = '0;
        if (Ready) begin
            if (state == WAIT)
                Instruction = MemDataIn;
            else if (cache_hit)
                Instruction = data[set_idx][word_idx];
            else
                Instruction = buf_data[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid          <= '0;
            buf_valid      <= 1'b0;
            MemReadAddress <= '0;
        end else begin
            if (miss) begin
                valid[set_idx] <= 1'b0;
                MemReadAddress <= ReadAddress;
            end
            if (demand_last) begin
                valid[miss_set] <= 1'b1;
                tags[miss_set]  <= miss_tag;
                buf_valid       <= 1'b0;
            end
            if (prefetch_last) begin
                buf_valid <= 1'b1;
                buf_blk   <= miss_blk + BLK_BITS'(1);
            end
            if (promote) begin
                valid[buf_set] <= 1'b1;
                tags[buf_set]  <= buf_tag;
                buf_valid      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (demand_we)
            data[miss_set][demand_slot] <= MemDataIn;
        if (prefetch_we)
            buf_data[prefetch_slot] <= MemDataIn;
        if (promote) begin
            for (int w = 0; w < BLOCK_WORDS; w++)
                data[buf_set][w] <= buf_data[w];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_icache.sv
`default_nettype none
// ============================================================================
// tb_ucsbece154_icache : directed scenarios against a behavioural burst memory
// Revision: 1.0
// ============================================================================
module tb_ucsbece154_icache;

    logic        clk = 1'b0;
    logic        reset, ReadEnable, Ready, MemReadRequest, MemDataReady;
    logic [31:0] ReadAddress, Instruction, MemReadAddress, MemDataIn;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] KEY       = 32'hC0DE0000;
    localparam logic [31:0] NOISE_ADR = 32'h00010014;

    always #5 clk = ~clk;

    ucsbece154_icache #(.NUM_SETS(8), .BLOCK_WORDS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    // Byte address carried by burst beat b for a miss on a.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int b);
        logic [27:0] blk;
        logic [1:0]  w;
        blk = a[31:4];
        if (b < 4) begin
            w = a[3:2] + 2'(b);
        end else begin
            blk = blk + 28'd1;
            w   = 2'(b - 4);
        end
        return {blk, w, 2'b00};
    endfunction

    task automatic do_miss(input logic [31:0] a, input int rst_beat);
        @(negedge clk); ReadEnable = 1'b1; ReadAddress = a; #1;
        checks++;
        if (Ready !== 1'b0 || Instruction !== 32'h0) begin
            errors++;
            $display("FAIL miss_detect a=%h: Ready=%b Instruction=%h, want 0 and 0", a, Ready, Instruction);
        end
        @(negedge clk); ReadAddress = NOISE_ADR; #1;
        checks++;
        if (MemReadRequest !== 1'b1 || MemReadAddress !== a) begin
            errors++;
            $display("FAIL mem_request a=%h: req=%b addr=%h, want 1 and %h", a, MemReadRequest, MemReadAddress, a);
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            MemDataReady = 1'b1;
            MemDataIn    = mw(beat_addr(a, b));
            if (b == rst_beat) reset = 1'b1;
            #1;
            if (b == 0) begin
                checks++;
                if (Ready !== 1'b1 || Instruction !== mw(a)) begin
                    errors++;
                    $display("FAIL critical_word a=%h: Ready=%b Instruction=%h, want 1 and %h", a, Ready, Instruction, mw(a));
                end
            end else if (b != rst_beat) begin
                checks++;
                if (Ready !== 1'b0 || Instruction !== 32'h0 || MemReadRequest !== 1'b0 || MemReadAddress !== a) begin
                    errors++;
                    $display("FAIL fill_beat%0d a=%h: Ready=%b Instr=%h req=%b addr=%h, want 0/0/0/%h",
                             b, a, Ready, Instruction, MemReadRequest, MemReadAddress, a);
                end
            end
            if (b == rst_beat) begin
                @(negedge clk); reset = 1'b0; MemDataReady = 1'b0; ReadEnable = 1'b0; #1;
                checks++;
                if (Ready !== 1'b0 || MemReadRequest !== 1'b0 || MemReadAddress !== 32'h0 || Instruction !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_mid_burst: Ready=%b req=%b addr=%h Instr=%h, want all 0",
                             Ready, MemReadRequest, MemReadAddress, Instruction);
                end
                return;
            end
        end
        @(negedge clk); MemDataReady = 1'b0; ReadEnable = 1'b0;
    endtask

    task automatic read_hit(input logic [31:0] a);
        @(negedge clk); ReadEnable = 1'b1; ReadAddress = a; #1;
        checks++;
        if (Ready !== 1'b1 || Instruction !== mw(a)) begin
            errors++;
            $display("FAIL hit a=%h: Ready=%b Instruction=%h, want 1 and %h", a, Ready, Instruction, mw(a));
        end
        @(negedge clk); ReadEnable = 1'b0; #1;
        checks++;
        if (MemReadRequest !== 1'b0) begin
            errors++;
            $display("FAIL hit_no_request a=%h: req=%b, want 0", a, MemReadRequest);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1; ReadEnable = 1'b1; ReadAddress = 32'h00010000;
        @(negedge clk); #1;
        checks++;
        if (Ready !== 1'b0 || MemReadRequest !== 1'b0 || MemReadAddress !== 32'h0 || Instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: Ready=%b req=%b addr=%h Instr=%h, want all 0",
                     Ready, MemReadRequest, MemReadAddress, Instruction);
        end
        @(negedge clk); reset = 1'b0; ReadEnable = 1'b0;
    endtask

    task automatic test_cold_miss();
        do_miss(32'h00010004, -1);
        read_hit(32'h0001000C);
        read_hit(32'h00010000);
        read_hit(32'h00010008);
    endtask

    task automatic test_prefetch_promote();
        @(negedge clk); ReadEnable = 1'b1; ReadAddress = 32'h00010014; #1;
        checks++;
        if (Ready !== 1'b1 || Instruction !== mw(32'h00010014)) begin
            errors++;
            $display("FAIL buffer_hit: Ready=%b Instruction=%h, want 1 and %h", Ready, Instruction, mw(32'h00010014));
        end
        @(negedge clk); ReadAddress = 32'h00010018; #1;
        checks++;
        if (Ready !== 1'b0 || Instruction !== 32'h0 || MemReadRequest !== 1'b0) begin
            errors++;
            $display("FAIL promote_cycle: Ready=%b Instr=%h req=%b, want 0/0/0", Ready, Instruction, MemReadRequest);
        end
        @(negedge clk); #1;
        checks++;
        if (Ready !== 1'b1 || Instruction !== mw(32'h00010018)) begin
            errors++;
            $display("FAIL promoted_hit: Ready=%b Instruction=%h, want 1 and %h", Ready, Instruction, mw(32'h00010018));
        end
        @(negedge clk); ReadEnable = 1'b0;
        read_hit(32'h0001001C);
    endtask

    task automatic test_conflict();
        do_miss(32'h00010080, -1);
        read_hit(32'h00010084);
        do_miss(32'h00010000, -1);
        read_hit(32'h00010014);
    endtask

    task automatic test_idle_noise();
        @(negedge clk); ReadEnable = 1'b0; MemDataReady = 1'b1; MemDataIn = 32'hDEADBEEF; #1;
        checks++;
        if (Ready !== 1'b0 || Instruction !== 32'h0 || MemReadRequest !== 1'b0) begin
            errors++;
            $display("FAIL idle_data_ignored: Ready=%b Instr=%h req=%b, want 0/0/0", Ready, Instruction, MemReadRequest);
        end
        @(negedge clk); MemDataReady = 1'b0;
        read_hit(32'h00010004);
    endtask

    task automatic test_critical_last();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        do_miss(32'h0001000C, -1);
        read_hit(32'h0001000C);
        read_hit(32'h00010000);
        read_hit(32'h00010004);
        read_hit(32'h00010008);
    endtask

    task automatic test_reset_mid_burst();
        do_miss(32'h00010040, 2);
        do_miss(32'h00010000, -1);
        read_hit(32'h00010008);
    endtask

    task automatic test_wrap();
        do_miss(32'hFFFFFFF0, -1);
        read_hit(32'hFFFFFFFC);
        @(negedge clk); ReadEnable = 1'b1; ReadAddress = 32'h00000000; #1;
        checks++;
        if (Ready !== 1'b1 || Instruction !== mw(32'h00000000)) begin
            errors++;
            $display("FAIL wrap_buffer_hit: Ready=%b Instruction=%h, want 1 and %h", Ready, Instruction, mw(32'h0));
        end
        @(negedge clk); ReadEnable = 1'b0;
        @(negedge clk);
        read_hit(32'h00000008);
    endtask

    initial begin
        reset        = 1'b0;
        ReadEnable   = 1'b0;
        ReadAddress  = 32'h0;
        MemDataIn    = 32'h0;
        MemDataReady = 1'b0;
        test_reset();
        test_cold_miss();
        test_prefetch_promote();
        test_conflict();
        test_idle_noise();
        test_critical_last();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154_icache.md
UCSBECE154_ICACHE -- requirements
Module: ucsbece154_icache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of direct-mapped sets (power of 2).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, words per block; SHALL equal the instruction memory burst block size.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ReadEnable  input  1  fetch-stage request for the instruction at ReadAddress.
REQ-006 SHALL have port ReadAddress  input  32  byte address of the requested instruction, word aligned.
REQ-007 SHALL have port Instruction  output  32  instruction word, valid when Ready=1.
REQ-008 SHALL have port Ready  output  1  Instruction valid this cycle; fetch stage stalls while low.
REQ-009 SHALL have port MemReadRequest  output  1  single-cycle request to the instruction memory.
REQ-010 SHALL have port MemReadAddress  output  32  word address of the missing instruction.
REQ-011 SHALL have port MemDataIn  input  32  burst data from the instruction memory.
REQ-012 SHALL have port MemDataReady  input  1  MemDataIn valid this cycle.

Function
REQ-013 Address split SHALL be: [1:0] byte, next log2(BLOCK_WORDS) bits word, next log2(NUM_SETS) bits set, remainder tag.
REQ-014 Storage SHALL be NUM_SETS x {valid, tag, BLOCK_WORDS data} plus one prefetch buffer {valid, block address, BLOCK_WORDS data}.
REQ-015 Burst contract SHALL be: 2*BLOCK_WORDS consecutive MemDataReady cycles; words 0..BLOCK_WORDS-1 = demand block, critical word first, word index incrementing mod BLOCK_WORDS; words BLOCK_WORDS..2*BLOCK_WORDS-1 = next sequential block (block address+1), word 0 upward.
REQ-016 Cache SHALL track fill word index with its own counter; it SHALL NOT derive index from memory internals.
REQ-017 States SHALL be IDLE, WAIT, FILL_DEMAND, FILL_PREFETCH, PROMOTE.
REQ-018 IDLE, ReadEnable=1, cache hit: Ready=1 and Instruction=stored word combinationally in the same cycle (zero-cycle hit).
REQ-019 IDLE, ReadEnable=1, cache miss, prefetch buffer hit: Ready=1 and Instruction from buffer in the same cycle; next state PROMOTE, which copies the buffer into its set (valid=1, tag written) in one cycle, clears buffer valid, and returns to IDLE with Ready=0 during PROMOTE.
REQ-020 IDLE, ReadEnable=1, miss in both: Ready=0, MemReadRequest=1 for exactly one cycle, MemReadAddress=ReadAddress latched; next state WAIT; target set valid cleared.
REQ-021 MemReadAddress SHALL hold constant from request until the last burst word is accepted.
REQ-022 WAIT: on MemDataReady go to FILL_DEMAND processing of word 0 in that same cycle; Ready=1, Instruction=MemDataIn (critical word forwarding).
REQ-023 FILL_DEMAND: each MemDataReady cycle writes one word; after BLOCK_WORDS words set valid=1 with new tag, enter FILL_PREFETCH; Ready=0 except the critical-word cycle.
REQ-024 FILL_PREFETCH: write BLOCK_WORDS words into the buffer; on the last word set buffer valid=1 with block address = demand block+1, return to IDLE.
REQ-025 During WAIT/FILL_* Ready SHALL be 0 apart from REQ-022 and ReadEnable SHALL be ignored; no new MemReadRequest until IDLE.
REQ-026 Buffer valid SHALL be cleared at start of FILL_PREFETCH so a partial buffer is never hit.
REQ-027 Block address increment SHALL wrap modulo 2^(32-log2(BLOCK_WORDS)-2) with no error.
REQ-028 MemDataReady in IDLE or PROMOTE SHALL be ignored.
REQ-029 Instruction SHALL be 0 when Ready=0.

Reset
REQ-030 Reset SHALL clear all set valid bits, buffer valid, fill counter, and state to IDLE; outputs Ready=0, MemReadRequest=0, MemReadAddress=0, Instruction=0.
REQ-031 Reset mid-burst SHALL abandon the fill; no partially written set or buffer SHALL become valid.

Structure
REQ-032 State encoding, address-field widths and burst length 2*BLOCK_WORDS SHALL live in shared package ucsbece154_icache_pkg.
REQ-033 One sub-module SHALL be natural: ucsbece154_icache_fill_ctrl (state machine plus fill counter); arrays stay in the top.

Verification
REQ-034 Cold miss 0x00010004: one MemReadRequest, MemReadAddress=0x00010004; first MemDataReady cycle Ready=1, Instruction=word@0x00010004; set 0 valid after 4 words; buffer holds 0x00010010..1C.
REQ-035 After REQ-034, read 0x0001000C: Ready=1 same cycle, no MemReadRequest.
REQ-036 After REQ-034, read 0x00010014: buffer hit, Ready=1 same cycle, PROMOTE one cycle, then read 0x00010018 hits cache array with buffer valid=0.
REQ-037 Critical word last (0x0001000C): data order 0C,00,04,08 written to correct slots; subsequent reads of all four hit.
REQ-038 Reset asserted on 3rd burst word: state IDLE, all valids 0; next read 0x00010000 misses and issues a new request.
REQ-039 Conflict: read 0x00010000 then 0x00010080 (same set, NUM_SETS=8): second misses, evicts first; re-read of 0x00010000 misses.
